// File: rtl/accel_scheduler.sv
// accel_scheduler
//
// Sequences the pairwise gravity accelerator over a body table. For each body
// i it reads i's position, then streams every other body j through the
// accelerator one pair at a time. It feeds the running acceleration back into
// the accelerator and writes the final (a_x, a_y) for body i. Exactly one pair
// is in flight at a time. No floating-point arithmetic is done here; all
// values pass through bit-exact.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_start                 start a full pass (sampled only while idle)
//   o_busy, o_done          busy outside IDLE; one-cycle pulse at pass end
//   o_rd_en, o_rd_addr      body memory read (data returns one cycle later)
//   i_rd_x, i_rd_y, i_rd_m  body memory read data
//   o_b1_x, o_b1_y          body i position to the accelerator
//   o_b2_x, o_b2_y, o_m_b2  body j position and mass (zero outside ISSUE)
//   o_a_b1_x, o_a_b1_y      running acceleration in (zero outside ISSUE)
//   o_acc_valid             pair presented this cycle
//   i_a_b1_x, i_a_b1_y      accelerator result, ACC_LAT cycles after issue
//   o_wr_en, o_wr_addr      result write strobe and body index
//   o_wr_a_x, o_wr_a_y      final acceleration of body i
module accel_scheduler #(
    parameter int N_BODIES = 8,
    parameter int IDX_W    = 3,
    parameter int ACC_LAT  = 15
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_rd_en,
    output logic [IDX_W-1:0] o_rd_addr,
    input  logic [31:0]      i_rd_x,
    input  logic [31:0]      i_rd_y,
    input  logic [31:0]      i_rd_m,
    output logic [31:0]      o_b1_x,
    output logic [31:0]      o_b1_y,
    output logic [31:0]      o_b2_x,
    output logic [31:0]      o_b2_y,
    output logic [31:0]      o_m_b2,
    output logic [31:0]      o_a_b1_x,
    output logic [31:0]      o_a_b1_y,
    output logic             o_acc_valid,
    input  logic [31:0]      i_a_b1_x,
    input  logic [31:0]      i_a_b1_y,
    output logic             o_wr_en,
    output logic [IDX_W-1:0] o_wr_addr,
    output logic [31:0]      o_wr_a_x,
    output logic [31:0]      o_wr_a_y
);

    localparam int CNT_W = $clog2(ACC_LAT + 1);
    // Indices carry one extra bit so that j >= N_BODIES never wraps.
    localparam logic [IDX_W:0]   N_EXT    = (IDX_W + 1)'(N_BODIES);
    localparam logic [IDX_W:0]   LAST_I   = (IDX_W + 1)'(N_BODIES - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACC_LAT);

    typedef enum logic [2:0] {IDLE, RD_I, LD_I, RD_J, ISSUE, WAIT, WRITE, DONE} state_t;

    state_t           state;
    logic [IDX_W:0]   body_i;
    logic [IDX_W:0]   body_j;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      acc_x;
    logic [31:0]      acc_y;
    logic [31:0]      b1_x;
    logic [31:0]      b1_y;

    logic [IDX_W:0]   j_first;
    logic [IDX_W:0]   j_step;
    logic [IDX_W:0]   j_next;

    // First partner of body i, and the next partner skipping j == i.
    always_comb begin
        j_first = (body_i == '0) ? (IDX_W + 1)'(1) : '0;
        j_step  = body_j + (IDX_W + 1)'(1);
        j_next  = (j_step == body_i) ? j_step + (IDX_W + 1)'(1) : j_step;
    end

    // Memory read data is only valid in ISSUE, so the pair operands are
    // steered straight through rather than registered.
    assign o_b1_x   = b1_x;
    assign o_b1_y   = b1_y;
    assign o_b2_x   = (state == ISSUE) ? i_rd_x : 32'h0;
    assign o_b2_y   = (state == ISSUE) ? i_rd_y : 32'h0;
    assign o_m_b2   = (state == ISSUE) ? i_rd_m : 32'h0;
    assign o_a_b1_x = (state == ISSUE) ? acc_x  : 32'h0;
    assign o_a_b1_y = (state == ISSUE) ? acc_y  : 32'h0;

    // Control outputs are registered: each transition loads the values the
    // destination state presents.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            body_i      <= '0;
            body_j      <= '0;
            cnt         <= '0;
            acc_x       <= 32'h0;
            acc_y       <= 32'h0;
            b1_x        <= 32'h0;
            b1_y        <= 32'h0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_rd_en     <= 1'b0;
            o_rd_addr   <= '0;
            o_acc_valid <= 1'b0;
            o_wr_en     <= 1'b0;
            o_wr_addr   <= '0;
            o_wr_a_x    <= 32'h0;
            o_wr_a_y    <= 32'h0;
        end else begin
            o_done      <= 1'b0;
            o_rd_en     <= 1'b0;
            o_rd_addr   <= '0;
            o_acc_valid <= 1'b0;
            o_wr_en     <= 1'b0;
            o_wr_addr   <= '0;
            o_wr_a_x    <= 32'h0;
            o_wr_a_y    <= 32'h0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        body_i    <= '0;
                        state     <= RD_I;
                        o_busy    <= 1'b1;
                        o_rd_en   <= 1'b1;
                        o_rd_addr <= '0;
                    end
                end
                RD_I: state <= LD_I;
                LD_I: begin
                    b1_x   <= i_rd_x;
                    b1_y   <= i_rd_y;
                    acc_x  <= 32'h0;
                    acc_y  <= 32'h0;
                    body_j <= j_first;
                    if (j_first >= N_EXT) begin
                        state     <= WRITE;
                        o_wr_en   <= 1'b1;
                        o_wr_addr <= body_i[IDX_W-1:0];
                    end else begin
                        state     <= RD_J;
                        o_rd_en   <= 1'b1;
                        o_rd_addr <= j_first[IDX_W-1:0];
                    end
                end
                RD_J: begin
                    state       <= ISSUE;
                    o_acc_valid <= 1'b1;
                end
                ISSUE: begin
                    cnt   <= CNT_LOAD;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    // Last wait cycle: the accelerator output for this pair is valid.
                    if (cnt == CNT_W'(1)) begin
                        acc_x  <= i_a_b1_x;
                        acc_y  <= i_a_b1_y;
                        body_j <= j_next;
                        if (j_next >= N_EXT) begin
                            state     <= WRITE;
                            o_wr_en   <= 1'b1;
                            o_wr_addr <= body_i[IDX_W-1:0];
                            o_wr_a_x  <= i_a_b1_x;
                            o_wr_a_y  <= i_a_b1_y;
                        end else begin
                            state     <= RD_J;
                            o_rd_en   <= 1'b1;
                            o_rd_addr <= j_next[IDX_W-1:0];
                        end
                    end
                end
                WRITE: begin
                    if (body_i == LAST_I) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                    end else begin
                        body_i    <= body_i + (IDX_W + 1)'(1);
                        state     <= RD_I;
                        o_rd_en   <= 1'b1;
                        o_rd_addr <= body_i[IDX_W-1:0] + IDX_W'(1);
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accel_scheduler.sv
// Bench for accel_scheduler. Four instances share one clock and reset:
//   0: N=4, ACC_LAT=15   1: N=3, ACC_LAT=3   2: N=1, ACC_LAT=15   3: N=2, ACC_LAT=15
// Each has a registered body memory and a stub accelerator (delay line that
// returns a_x+1, a_y+2 for presented pairs and zero otherwise).
module tb_accel_scheduler;

    localparam int NI = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start[NI];
    logic        busy[NI];
    logic        done[NI];
    logic        rd_en[NI];
    logic [2:0]  rd_addr[NI];
    logic [31:0] rd_x[NI];
    logic [31:0] rd_y[NI];
    logic [31:0] rd_m[NI];
    logic [31:0] b1_x[NI];
    logic [31:0] b1_y[NI];
    logic [31:0] b2_x[NI];
    logic [31:0] b2_y[NI];
    logic [31:0] m_b2[NI];
    logic [31:0] ab_x[NI];
    logic [31:0] ab_y[NI];
    logic        acc_valid[NI];
    logic [31:0] ai_x[NI];
    logic [31:0] ai_y[NI];
    logic        wr_en[NI];
    logic [2:0]  wr_addr[NI];
    logic [31:0] wr_x[NI];
    logic [31:0] wr_y[NI];

    int checks = 0;
    int errors = 0;

    int q_rd[$];
    int q_pi[$];
    int q_pj[$];
    int q_pk[$];
    int q_wa[$];
    int q_wk[$];

    function automatic int nb(input int g);
        return (g == 0) ? 4 : (g == 1) ? 3 : (g == 2) ? 1 : 2;
    endfunction

    function automatic int lat(input int g);
        return (g == 1) ? 3 : 15;
    endfunction

    function automatic logic [31:0] body_x(input int g, input int idx);
        if (g == 3) return (idx == 0) ? 32'h40E00000 : 32'h3F800000;
        return 32'h40000001 | 32'(g << 12) | 32'(idx << 4);
    endfunction

    function automatic logic [31:0] body_y(input int g, input int idx);
        if (g == 3) return (idx == 0) ? 32'h40E00000 : 32'h3F800000;
        return 32'h41000002 | 32'(g << 12) | 32'(idx << 4);
    endfunction

    function automatic logic [31:0] body_m(input int g, input int idx);
        if (g == 3) return 32'h3F800000;
        return 32'h3F000003 | 32'(g << 12) | 32'(idx << 4);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int NBG  = (g == 0) ? 4 : (g == 1) ? 3 : (g == 2) ? 1 : 2;
        localparam int LATG = (g == 1) ? 3 : 15;

        logic [31:0] mx;
        logic [31:0] my;
        logic [31:0] mm;
        logic [31:0] px[LATG];
        logic [31:0] py[LATG];

        accel_scheduler #(.N_BODIES(NBG), .IDX_W(3), .ACC_LAT(LATG)) u_dut (
            .i_clk(clk), .i_rst(rst), .i_start(start[g]),
            .o_busy(busy[g]), .o_done(done[g]),
            .o_rd_en(rd_en[g]), .o_rd_addr(rd_addr[g]),
            .i_rd_x(rd_x[g]), .i_rd_y(rd_y[g]), .i_rd_m(rd_m[g]),
            .o_b1_x(b1_x[g]), .o_b1_y(b1_y[g]),
            .o_b2_x(b2_x[g]), .o_b2_y(b2_y[g]), .o_m_b2(m_b2[g]),
            .o_a_b1_x(ab_x[g]), .o_a_b1_y(ab_y[g]), .o_acc_valid(acc_valid[g]),
            .i_a_b1_x(ai_x[g]), .i_a_b1_y(ai_y[g]),
            .o_wr_en(wr_en[g]), .o_wr_addr(wr_addr[g]),
            .o_wr_a_x(wr_x[g]), .o_wr_a_y(wr_y[g])
        );

        always @(posedge clk) begin
            if (rd_en[g]) begin
                mx <= body_x(g, int'(rd_addr[g]));
                my <= body_y(g, int'(rd_addr[g]));
                mm <= body_m(g, int'(rd_addr[g]));
            end
            px[0] <= acc_valid[g] ? ab_x[g] + 32'd1 : 32'd0;
            py[0] <= acc_valid[g] ? ab_y[g] + 32'd2 : 32'd0;
            for (int k = 1; k < LATG; k++) begin
                px[k] <= px[k-1];
                py[k] <= py[k-1];
            end
        end

        assign rd_x[g] = mx;
        assign rd_y[g] = my;
        assign rd_m[g] = mm;
        assign ai_x[g] = px[LATG-1];
        assign ai_y[g] = py[LATG-1];
    end

    // Runs one pass on instance g, scoring reads, pairs, writes and timing.
    task automatic run_pass(input int g, input bit hold);
        int n, l, k, exp_len, len, cyc, last_wr, v;
        bit seen_done;
        n = nb(g);
        l = lat(g);
        q_rd.delete(); q_pi.delete(); q_pj.delete(); q_pk.delete(); q_wa.delete(); q_wk.delete();
        for (int i = 0; i < n; i++) begin
            k = 0;
            q_rd.push_back(i);
            for (int j = 0; j < n; j++) begin
                if (j != i) begin
                    q_rd.push_back(j);
                    q_pi.push_back(i);
                    q_pj.push_back(j);
                    q_pk.push_back(k);
                    k++;
                end
            end
            q_wa.push_back(i);
            q_wk.push_back(k);
        end
        exp_len = n * (3 + (n - 1) * (l + 2)) + 1;

        @(negedge clk);
        start[g] = 1'b1;
        cyc = 0; len = 0; last_wr = -10; seen_done = 1'b0;
        while (!seen_done && cyc < exp_len + 50) begin
            @(negedge clk);
            cyc++;
            if (!hold) start[g] = 1'b0;
            if (busy[g]) len++;
            if (rd_en[g]) begin
                checks++;
                if (q_rd.size() == 0) begin
                    errors++;
                    $display("FAIL rd_addr[%0d]: got unexpected read of %0d, required none", g, rd_addr[g]);
                end else begin
                    v = q_rd.pop_front();
                    if (rd_addr[g] !== 3'(v)) begin
                        errors++;
                        $display("FAIL rd_addr[%0d]: got %0d, required %0d", g, rd_addr[g], v);
                    end
                end
            end
            if (acc_valid[g]) begin
                checks++;
                if (q_pi.size() == 0) begin
                    errors++;
                    $display("FAIL pair[%0d]: got unexpected issue, required none", g);
                end else begin
                    int pi, pj, pk;
                    pi = q_pi.pop_front(); pj = q_pj.pop_front(); pk = q_pk.pop_front();
                    if ({b1_x[g], b1_y[g], b2_x[g], b2_y[g], m_b2[g]} !==
                        {body_x(g, pi), body_y(g, pi), body_x(g, pj), body_y(g, pj), body_m(g, pj)}) begin
                        errors++;
                        $display("FAIL pair_data[%0d]: got b1=%h,%h b2=%h,%h m=%h, required pair i=%0d j=%0d", g,
                                 b1_x[g], b1_y[g], b2_x[g], b2_y[g], m_b2[g], pi, pj);
                    end
                    checks++;
                    if ({ab_x[g], ab_y[g]} !== {32'(pk), 32'(2 * pk)}) begin
                        errors++;
                        $display("FAIL pair_acc[%0d]: got %h,%h, required %h,%h", g, ab_x[g], ab_y[g], pk, 2 * pk);
                    end
                end
            end else begin
                checks++;
                if ({b2_x[g], b2_y[g], m_b2[g], ab_x[g], ab_y[g]} !== 160'h0) begin
                    errors++;
                    $display("FAIL idle_operands[%0d]: got b2=%h a=%h, required 0", g, b2_x[g], ab_x[g]);
                end
            end
            if (wr_en[g]) begin
                last_wr = cyc;
                checks++;
                if (q_wa.size() == 0) begin
                    errors++;
                    $display("FAIL write[%0d]: got unexpected write to %0d, required none", g, wr_addr[g]);
                end else begin
                    int wa, wk;
                    wa = q_wa.pop_front(); wk = q_wk.pop_front();
                    if ({wr_addr[g], wr_x[g], wr_y[g]} !== {3'(wa), 32'(wk), 32'(2 * wk)}) begin
                        errors++;
                        $display("FAIL write[%0d]: got addr %0d a=%h,%h, required addr %0d a=%h,%h", g,
                                 wr_addr[g], wr_x[g], wr_y[g], wa, wk, 2 * wk);
                    end
                end
            end
            if (done[g]) begin
                seen_done = 1'b1;
                checks++;
                if (last_wr != cyc - 1) begin
                    errors++;
                    $display("FAIL done_after_write[%0d]: last write at cycle %0d, done at %0d, required one cycle apart",
                             g, last_wr, cyc);
                end
            end
        end
        checks++;
        if (!seen_done) begin
            errors++;
            $display("FAIL done_timeout[%0d]: no done within %0d cycles, required done", g, exp_len + 50);
        end
        checks++;
        if (len != exp_len) begin
            errors++;
            $display("FAIL pass_length[%0d]: got %0d cycles, required %0d", g, len, exp_len);
        end
        checks++;
        if (q_rd.size() + q_pi.size() + q_wa.size() != 0) begin
            errors++;
            $display("FAIL leftovers[%0d]: got %0d reads %0d pairs %0d writes outstanding, required 0", g,
                     q_rd.size(), q_pi.size(), q_wa.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int g = 0; g < NI; g++) start[g] = 1'b0;
        repeat (2) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            checks++;
            if ({busy[g], done[g], rd_en[g], acc_valid[g], wr_en[g], rd_addr[g], wr_addr[g]} !== 11'h0) begin
                errors++;
                $display("FAIL reset_ctrl[%0d]: got busy=%b done=%b rd=%b vld=%b wr=%b, required all 0", g,
                         busy[g], done[g], rd_en[g], acc_valid[g], wr_en[g]);
            end
            checks++;
            if ({b1_x[g], b1_y[g], b2_x[g], b2_y[g], m_b2[g], ab_x[g], ab_y[g], wr_x[g], wr_y[g]} !== 288'h0) begin
                errors++;
                $display("FAIL reset_data[%0d]: got b1=%h b2=%h a=%h wr=%h, required 0", g,
                         b1_x[g], b2_x[g], ab_x[g], wr_x[g]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_stub_pass();
        run_pass(0, 1'b0);
        @(negedge clk);
        checks++;
        if ({busy[0], done[0]} !== 2'b00) begin
            errors++;
            $display("FAIL after_done: got busy=%b done=%b, required 0 0", busy[0], done[0]);
        end
    endtask

    task automatic test_pair_n2();
        run_pass(3, 1'b0);
    endtask

    task automatic test_skip_rule();
        run_pass(1, 1'b0);
    endtask

    task automatic test_single_body();
        run_pass(2, 1'b0);
    endtask

    task automatic test_reset_mid_pass();
        int seen, cyc, bad;
        @(negedge clk);
        start[0] = 1'b1;
        seen = 0; cyc = 0;
        while (seen < 3 && cyc < 500) begin
            @(negedge clk);
            start[0] = 1'b0;
            cyc++;
            if (acc_valid[0]) seen++;
        end
        checks++;
        if (seen < 3) begin
            errors++;
            $display("FAIL mid_reset_wait: got %0d pairs in %0d cycles, required 3", seen, cyc);
        end
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy[0], done[0], rd_en[0], acc_valid[0], wr_en[0], rd_addr[0], wr_addr[0]} !== 11'h0 ||
            {b1_x[0], b1_y[0], b2_x[0], b2_y[0], m_b2[0], ab_x[0], ab_y[0], wr_x[0], wr_y[0]} !== 288'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got busy=%b rd=%b vld=%b wr=%b b1=%h, required all 0",
                     busy[0], rd_en[0], acc_valid[0], wr_en[0], b1_x[0]);
        end
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (wr_en[0] || done[0] || busy[0]) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mid_reset_quiet: got %0d cycles with write/done/busy, required 0", bad);
        end
        run_pass(0, 1'b0);
    endtask

    task automatic test_start_while_busy();
        int idle;
        run_pass(0, 1'b1);
        idle = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (busy[0]) break;
            idle++;
        end
        checks++;
        if (idle != 1) begin
            errors++;
            $display("FAIL restart_gap: got %0d idle cycles between passes, required 1", idle);
        end
        start[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stub_pass();
        test_pair_n2();
        test_skip_rule();
        test_single_body();
        test_reset_mid_pass();
        test_start_while_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
